// File: rtl/rsa_result_tx.sv
// rsa_result_tx: buffers MonExp result words and sends them over UART 8N1, MSB byte first.
// Define RSA_TX_PARITY_EN to insert an even-parity bit between the data and stop bits (8E1).
module rsa_result_tx #(
    parameter int DATA_WIDTH   = 32,
    parameter int CLKS_PER_BIT = 87,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DATA_WIDTH-1:0]       word_in,
    input  logic                        word_valid,
    output logic                        word_ready,
    output logic                        o_Tx_Serial,
    output logic                        tx_active,
    output logic                        tx_done,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW    = $clog2(BYTES) + 1;
    localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];
`ifdef RSA_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;
`endif
    state_t                state, state_n;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [CW-1:0]         baud_cnt;
    logic [2:0]            bit_idx;
    logic [BW-1:0]         byte_idx;
    logic                  push, pop, baud_done, last_byte;
    logic [7:0]            cur_byte;

    assign word_ready = fifo_count < DEPTH_C;
    assign push       = word_valid && word_ready;
    assign pop        = state == LOAD;
    assign baud_done  = baud_cnt == CW'(CLKS_PER_BIT - 1);
    assign last_byte  = byte_idx == BW'(BYTES - 1);
    assign cur_byte   = shift_reg[DATA_WIDTH-1 -: 8];

    // Word storage; contents need no reset because the count gates every read
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= word_in;

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            fifo_count <= fifo_count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            if (word_valid && !word_ready) overflow <= 1'b1;
        end

    // State register
    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else state <= state_n;

    // Next-state logic: bytes of a word are sent back to back, words are separated by IDLE+LOAD
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (fifo_count != '0) state_n = LOAD;
            LOAD:    state_n = START;
            START:   if (baud_done) state_n = DATA;
`ifdef RSA_TX_PARITY_EN
            DATA:    if (baud_done && bit_idx == 3'd7) state_n = PARITY;
            PARITY:  if (baud_done) state_n = STOP;
`else
            DATA:    if (baud_done && bit_idx == 3'd7) state_n = STOP;
`endif
            STOP:    if (baud_done) state_n = last_byte ? IDLE : START;
            default: state_n = IDLE;
        endcase
    end

    // Line and activity outputs decoded from the state
    always_comb begin
        o_Tx_Serial = 1'b1;
        if (state == START) o_Tx_Serial = 1'b0;
        else if (state == DATA) o_Tx_Serial = cur_byte[bit_idx];
`ifdef RSA_TX_PARITY_EN
        else if (state == PARITY) o_Tx_Serial = ^cur_byte;
`endif
        tx_active = state != IDLE && state != LOAD;
    end

    // Baud timing, bit/byte indices, word shift register and end-of-word pulse
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            baud_cnt  <= '0;
            bit_idx   <= '0;
            byte_idx  <= '0;
            shift_reg <= '0;
            tx_done   <= 1'b0;
        end else begin
            tx_done  <= 1'b0;
            baud_cnt <= (state == IDLE || state == LOAD || baud_done) ? '0 : baud_cnt + CW'(1);
            if (pop) begin
                shift_reg <= mem[rd_ptr];
                byte_idx  <= '0;
                bit_idx   <= '0;
            end
            if (state == DATA && baud_done) bit_idx <= bit_idx + 3'd1;
            if (state == STOP && baud_done) begin
                if (last_byte) tx_done <= 1'b1;
                else begin
                    byte_idx  <= byte_idx + BW'(1);
                    shift_reg <= shift_reg << 8;
                end
            end
        end
endmodule

// File: tb/tb_rsa_result_tx.sv
// tb_rsa_result_tx: directed bench with a UART line decoder and a word scoreboard for rsa_result_tx
module tb_rsa_result_tx;
    localparam int DW = 32;
    localparam int C  = 4;
    localparam int D  = 4;
`ifdef RSA_TX_PARITY_EN
    localparam int FRAME = 11;
`else
    localparam int FRAME = 10;
`endif
    localparam int WORD_CYC = (DW / 8) * FRAME * C;

    logic clk = 1'b0, reset = 1'b0, word_valid = 1'b0;
    logic [DW-1:0] word_in = '0;
    logic word_ready, o_Tx_Serial, tx_active, tx_done, overflow;
    logic [$clog2(D):0] fifo_count;
    int n_chk = 0, n_fail = 0, cyc = 0, done_cnt = 0;
    logic [DW-1:0] exp_q [$];
    logic seq [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    rsa_result_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
        .clk(clk), .reset(reset), .word_in(word_in), .word_valid(word_valid),
        .word_ready(word_ready), .o_Tx_Serial(o_Tx_Serial), .tx_active(tx_active),
        .tx_done(tx_done), .fifo_count(fifo_count), .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] w, input logic acc);
        check("word_ready", word_ready, acc);
        word_in = w;
        word_valid = 1'b1;
        if (acc) exp_q.push_back(w);
        tick;
        word_valid = 1'b0;
    endtask

    task automatic wait_tx_done(input string tag);
        int b = 0;
        while (tx_done !== 1'b1 && b < 2 * WORD_CYC) begin
            tick;
            b++;
        end
        check(tag, tx_done, 1'b1);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            wait_tx_done("drain_done");
            tick;
        end
    endtask

    task automatic check_reset_state;
        check("rst_line", o_Tx_Serial, 1'b1);
        check("rst_active", tx_active, 1'b0);
        check("rst_done", tx_done, 1'b0);
        check("rst_count", fifo_count, 0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_ready", word_ready, 1'b1);
    endtask

    // Line decoder: samples each bit mid-way, checks framing and compares whole words to the scoreboard
    int m_cnt = 0, m_nb = 0;
    logic m_busy = 1'b0;
    logic [7:0] m_b = '0;
    logic [DW-1:0] m_w = '0;
    always @(negedge clk) begin : mon
        int k;
        if (tx_done === 1'b1) done_cnt++;
        if (!reset) begin
            m_busy = 1'b0;
            m_nb = 0;
        end else if (!m_busy) begin
            if (o_Tx_Serial === 1'b0) begin
                m_busy = 1'b1;
                m_cnt = 0;
            end
        end else begin
            m_cnt++;
            if (m_cnt % C == C / 2) begin
                k = m_cnt / C;
                if (k == 0) check("start_bit", o_Tx_Serial, 1'b0);
                else if (k <= 8) m_b[k-1] = o_Tx_Serial;
                else if (k < FRAME - 1) check("parity_bit", o_Tx_Serial, ^m_b);
                else begin
                    check("stop_bit", o_Tx_Serial, 1'b1);
                    m_w = {m_w[DW-9:0], m_b};
                    m_busy = 1'b0;
                    m_nb++;
                    if (m_nb == DW / 8) begin
                        m_nb = 0;
                        check("sb_nonempty", exp_q.size() != 0, 1'b1);
                        if (exp_q.size() != 0) check("rx_word", m_w, exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, %0d assertions evaluated", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, d0, n;
        logic saw;
        #3;
        check_reset_state;
        #20 reset = 1'b1;
        tick;
        // single word: latency, first-byte waveform, completion time
        push(32'hA1B2C3D4, 1'b1);
        t0 = cyc;
        check("count_after_push", fifo_count, 1);
        tick;
        check("load_line_high", o_Tx_Serial, 1'b1);
        check("load_inactive", tx_active, 1'b0);
        tick;
        check("start_fall", o_Tx_Serial, seq[0]);
        check("start_active", tx_active, 1'b1);
        check("popped", fifo_count, 0);
        for (int k = 1; k < 10; k++) begin
            repeat (C) tick;
            check("byte0_line", o_Tx_Serial, seq[k]);
        end
        wait_tx_done("done_single");
        check("done_latency", cyc - t0, 2 + WORD_CYC);
        tick;
        check("done_one_cycle", tx_done, 1'b0);
        check("idle_inactive", tx_active, 1'b0);
        check("sb_empty_single", exp_q.size(), 0);
        // back-to-back words: two-cycle gap, two pulses
        d0 = done_cnt;
        push(32'h00000001, 1'b1);
        push(32'hFFFFFFFF, 1'b1);
        wait_tx_done("done_b2b_a");
        n = 0;
        while (o_Tx_Serial === 1'b1 && n < 20) begin
            tick;
            n++;
        end
        check("gap_cycles", n, 2);
        wait_tx_done("done_b2b_b");
        tick;
        check("b2b_pulses", done_cnt - d0, 2);
        // fill past capacity while the first word transmits
        push(32'h11223344, 1'b1);
        push(32'hDEADBEEF, 1'b1);
        push(32'h07000000, 1'b1);
        push(32'h80000001, 1'b1);
        push(32'h5A5AA5A5, 1'b1);
        push(32'hCAFEF00D, 1'b0);
        check("full_count", fifo_count, 4);
        check("full_ready", word_ready, 1'b0);
        check("overflow_set", overflow, 1'b1);
        drain(5);
        check("overflow_sticky", overflow, 1'b1);
        check("sb_empty_full", exp_q.size(), 0);
        // reset clears the sticky flag
        #3 reset = 1'b0;
        #1 check_reset_state;
        #2 reset = 1'b1;
        tick;
        // push on the pop edge: rejected at count 4, accepted at count 3
        push(32'h01020304, 1'b1);
        push(32'h05060708, 1'b1);
        push(32'h090A0B0C, 1'b1);
        push(32'h0D0E0F10, 1'b1);
        push(32'h11121314, 1'b1);
        wait_tx_done("done_pre_load4");
        tick;
        check("load_count4", fifo_count, 4);
        push(32'hBAD0BAD0, 1'b0);
        check("load_push_overflow", overflow, 1'b1);
        check("load_count_after_pop", fifo_count, 3);
        wait_tx_done("done_pre_load3");
        tick;
        check("load_count3", fifo_count, 3);
        push(32'h600DF00D, 1'b1);
        check("push_pop_count", fifo_count, 3);
        drain(4);
        check("sb_empty_load", exp_q.size(), 0);
        check("drained_count", fifo_count, 0);
        // reset in the middle of data bit 3 of the second byte
        push(32'h12345678, 1'b1);
        push(32'h9ABCDEF0, 1'b1);
        repeat (57) tick;
        check("pre_reset_bit3", o_Tx_Serial, 1'b0);
        check("pre_reset_active", tx_active, 1'b1);
        #2 exp_q.delete();
        reset = 1'b0;
        #1;
        check("async_line_high", o_Tx_Serial, 1'b1);
        check("async_count", fifo_count, 0);
        check("async_active", tx_active, 1'b0);
        #2 reset = 1'b1;
        saw = 1'b0;
        repeat (100) begin
            tick;
            if (o_Tx_Serial !== 1'b1 || tx_active !== 1'b0) saw = 1'b1;
        end
        check("quiet_after_reset", saw, 1'b0);
        push(32'h0F1E2D3C, 1'b1);
        wait_tx_done("done_after_reset");
        tick;
        check("sb_empty_final", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
